axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Two-master, one-slave AXI4 read-channel arbiter. Shares the single AXI read port between the instruction fetch unit (master 0) and the load/store unit (master 1).
- Sits between IFU/LSU and the memory-side crossbar/SRAM.
- Allows one outstanding read transaction at a time. The grant is held from AR acceptance until the last R beat completes.

Parameters:
- ADDR_W, 32, address width of araddr.
- DATA_W, 32, read data width.
- ID_W, 4, width of arid/rid.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous active-high reset.
- i_mN_araddr/i_mN_arid/i_mN_arlen/i_mN_arsize/i_mN_arburst  in  ADDR_W/ID_W/8/3/2  AR payload from master N (N = 0 IFU, 1 LSU).
- i_mN_arvalid  in  1  AR valid from master N.
- o_mN_arready  out  1  AR ready to master N.
- o_mN_rdata/o_mN_rresp/o_mN_rid/o_mN_rlast  out  DATA_W/2/ID_W/1  R payload to master N.
- o_mN_rvalid  out  1  R valid to master N.
- i_mN_rready  in  1  R ready from master N.
- o_axi_araddr/o_axi_arid/o_axi_arlen/o_axi_arsize/o_axi_arburst  out  ADDR_W/ID_W/8/3/2  AR payload to slave.
- o_axi_arvalid  out  1  AR valid to slave.
- i_axi_arready  in  1  AR ready from slave.
- i_axi_rdata/i_axi_rresp/i_axi_rid/i_axi_rlast  in  DATA_W/2/ID_W/1  R payload from slave.
- i_axi_rvalid  in  1  R valid from slave.
- o_axi_rready  out  1  R ready to slave.
- o_grant  out  2  one-hot current owner; 00 when idle.
- o_busy  out  1  high in ST_AR or ST_R.

Behaviour:
- Registered state: state (ST_IDLE, ST_AR, ST_R) and grant[1:0]. On i_reset assertion (asynchronous): state=ST_IDLE, grant=00.
- All slave-side and master-side outputs are combinational from state, grant and inputs. With grant=00, every valid/ready output is 0 and every payload output is 0.
- ST_IDLE:
  - If any i_mN_arvalid is high, register the winner into grant and go to ST_AR.
  - Arbitration costs exactly 1 cycle; no ready/valid is forwarded while in ST_IDLE.
- Fixed priority (default build): m1 (LSU) beats m0 (IFU) when both arvalid are high in the same cycle.
- ST_AR:
  - o_axi_arvalid = granted arvalid; AR payload muxed from the granted master.
  - Granted o_mN_arready = i_axi_arready. The non-granted o_mN_arready = 0.
  - On o_axi_arvalid && i_axi_arready: go to ST_R.
  - If the granted master drops arvalid without a handshake (protocol violation), stay in ST_AR with o_axi_arvalid=0; no abort.
- ST_R:
  - Granted o_mN_rvalid = i_axi_rvalid; R payload forwarded. o_axi_rready = granted i_mN_rready.
  - Non-granted o_mN_rvalid = 0.
  - On i_axi_rvalid && o_axi_rready && i_axi_rlast: grant=00, go to ST_IDLE.
  - Non-last beats stay in ST_R; burst length is not counted.
  - i_axi_rid is forwarded and not checked.
- A new request seen on the same cycle as the last beat is not granted until the following cycle. Minimum spacing between transactions is therefore 1 idle cycle.
- rresp errors (SLVERR/DECERR) are forwarded unchanged and do not change the sequencing.
- Reset mid-transaction returns the block to ST_IDLE immediately. Any pending slave R beat after reset is dropped (rready=0); draining it is the slave's reset responsibility.
- Requests arriving while busy wait with arready=0 and must hold arvalid.

Optional Feature:
- Macro: AXI_RD_ARB_RR_EN.
- Defined:
  - Round-robin. A 1-bit last_owner register (reset 0 = m0) records the master of the most recently granted transaction.
  - On simultaneous requests in ST_IDLE, the master other than last_owner wins.
  - A single requester always wins regardless of last_owner.
- Undefined: fixed priority, m1 over m0; no last_owner register.

Test Plan:
- Single IFU read: m0 arvalid, araddr=0x8000_0000, arlen=0; slave arready same cycle, rdata=0x0000_0413 rlast=1 one cycle later -> o_grant=01 the cycle after request; m0 receives rdata 0x0000_0413; o_grant=00 after the beat.
- Simultaneous: m0 araddr=0x8000_0010 and m1 araddr=0x8000_1000 both valid in IDLE -> first slave AR carries 0x8000_1000, second carries 0x8000_0010. With AXI_RD_ARB_RR_EN and last_owner=m1, the order is reversed.
- Burst: m1 arlen=3, slave returns 4 beats with rlast on the 4th, m1 rready low for 2 cycles mid-burst -> o_axi_rready mirrors rready; grant held all 4 beats; m0 request during the burst is stalled with arready=0.
- Slave AR back-pressure: i_axi_arready low for 5 cycles -> o_axi_arvalid and payload are stable for 5 cycles; state remains ST_AR.
- Reset mid-burst: assert i_reset after beat 2 of 4 -> o_busy=0, o_grant=00, all valid/ready outputs 0 in the same cycle (asynchronous). After release, a new m0 request is granted normally.
- Error response: slave returns rresp=2'b10 with rlast -> m1 sees rresp=2'b10; block returns to ST_IDLE.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter (IFU = m0, LSU = m1), one transaction in flight.
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; default is fixed priority m1 > m0.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,

  input  logic [ADDR_W-1:0] i_m0_araddr,
  input  logic [ID_W-1:0]   i_m0_arid,
  input  logic [7:0]        i_m0_arlen,
  input  logic [2:0]        i_m0_arsize,
  input  logic [1:0]        i_m0_arburst,
  input  logic              i_m0_arvalid,
  output logic              o_m0_arready,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic [1:0]        o_m0_rresp,
  output logic [ID_W-1:0]   o_m0_rid,
  output logic              o_m0_rlast,
  output logic              o_m0_rvalid,
  input  logic              i_m0_rready,

  input  logic [ADDR_W-1:0] i_m1_araddr,
  input  logic [ID_W-1:0]   i_m1_arid,
  input  logic [7:0]        i_m1_arlen,
  input  logic [2:0]        i_m1_arsize,
  input  logic [1:0]        i_m1_arburst,
  input  logic              i_m1_arvalid,
  output logic              o_m1_arready,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [1:0]        o_m1_rresp,
  output logic [ID_W-1:0]   o_m1_rid,
  output logic              o_m1_rlast,
  output logic              o_m1_rvalid,
  input  logic              i_m1_rready,

  output logic [ADDR_W-1:0] o_axi_araddr,
  output logic [ID_W-1:0]   o_axi_arid,
  output logic [7:0]        o_axi_arlen,
  output logic [2:0]        o_axi_arsize,
  output logic [1:0]        o_axi_arburst,
  output logic              o_axi_arvalid,
  input  logic              i_axi_arready,
  input  logic [DATA_W-1:0] i_axi_rdata,
  input  logic [1:0]        i_axi_rresp,
  input  logic [ID_W-1:0]   i_axi_rid,
  input  logic              i_axi_rlast,
  input  logic              i_axi_rvalid,
  output logic              o_axi_rready,

  output logic [1:0]        o_grant,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_R
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] grant;
  logic [1:0] grant_nx;
  logic [1:0] pick;

  logic ar_ph;
  logic r_ph;
  logic a0;
  logic a1;
  logic r0;
  logic r1;

`ifdef AXI_RD_ARB_RR_EN
  logic last_owner;
  logic last_owner_nx;

  // On a tie, the master that did not own the previous transaction wins.
  always_comb begin
    pick = {i_m1_arvalid, i_m0_arvalid};
    if (i_m0_arvalid && i_m1_arvalid)
      pick = last_owner ? 2'b01 : 2'b10;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) last_owner <= 1'b0;
    else         last_owner <= last_owner_nx;
  end
`else
  always_comb begin
    pick = i_m1_arvalid ? 2'b10 : {1'b0, i_m0_arvalid};
  end
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
      grant <= 2'b00;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
`ifdef AXI_RD_ARB_RR_EN
    last_owner_nx = last_owner;
`endif
    unique case (state)
      ST_IDLE: begin
        if (i_m0_arvalid || i_m1_arvalid) begin
          grant_nx = pick;
          state_nx = ST_AR;
`ifdef AXI_RD_ARB_RR_EN
          last_owner_nx = pick[1];
`endif
        end
      end
      ST_AR: begin
        if (o_axi_arvalid && i_axi_arready)
          state_nx = ST_R;
      end
      ST_R: begin
        if (i_axi_rvalid && o_axi_rready && i_axi_rlast) begin
          grant_nx = 2'b00;
          state_nx = ST_IDLE;
        end
      end
      default: begin
        grant_nx = 2'b00;
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Per-master phase enables; all forwarding is gated by these.
  assign ar_ph = (state == ST_AR);
  assign r_ph  = (state == ST_R);
  assign a0    = ar_ph & grant[0];
  assign a1    = ar_ph & grant[1];
  assign r0    = r_ph & grant[0];
  assign r1    = r_ph & grant[1];

  assign o_axi_arvalid = (a0 & i_m0_arvalid) | (a1 & i_m1_arvalid);
  assign o_axi_araddr  = ({ADDR_W{a0}} & i_m0_araddr)
                       | ({ADDR_W{a1}} & i_m1_araddr);
  assign o_axi_arid    = ({ID_W{a0}} & i_m0_arid)
                       | ({ID_W{a1}} & i_m1_arid);
  assign o_axi_arlen   = ({8{a0}} & i_m0_arlen)
                       | ({8{a1}} & i_m1_arlen);
  assign o_axi_arsize  = ({3{a0}} & i_m0_arsize)
                       | ({3{a1}} & i_m1_arsize);
  assign o_axi_arburst = ({2{a0}} & i_m0_arburst)
                       | ({2{a1}} & i_m1_arburst);

  assign o_m0_arready = a0 & i_axi_arready;
  assign o_m1_arready = a1 & i_axi_arready;

  assign o_axi_rready = (r0 & i_m0_rready) | (r1 & i_m1_rready);

  assign o_m0_rvalid = r0 & i_axi_rvalid;
  assign o_m0_rdata  = {DATA_W{r0}} & i_axi_rdata;
  assign o_m0_rresp  = {2{r0}} & i_axi_rresp;
  assign o_m0_rid    = {ID_W{r0}} & i_axi_rid;
  assign o_m0_rlast  = r0 & i_axi_rlast;

  assign o_m1_rvalid = r1 & i_axi_rvalid;
  assign o_m1_rdata  = {DATA_W{r1}} & i_axi_rdata;
  assign o_m1_rresp  = {2{r1}} & i_axi_rresp;
  assign o_m1_rid    = {ID_W{r1}} & i_axi_rid;
  assign o_m1_rlast  = r1 & i_axi_rlast;

  assign o_grant = grant;
  assign o_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: cycle table, directed corner sequences,
// then random traffic checked end-to-end against a transaction scoreboard.
module tb_axi_rd_arbiter;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_m0_araddr, i_m1_araddr;
  logic [3:0]  i_m0_arid, i_m1_arid;
  logic [7:0]  i_m0_arlen, i_m1_arlen;
  logic [2:0]  i_m0_arsize, i_m1_arsize;
  logic [1:0]  i_m0_arburst, i_m1_arburst;
  logic        i_m0_arvalid, i_m1_arvalid;
  logic        o_m0_arready, o_m1_arready;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic [1:0]  o_m0_rresp, o_m1_rresp;
  logic [3:0]  o_m0_rid, o_m1_rid;
  logic        o_m0_rlast, o_m1_rlast;
  logic        o_m0_rvalid, o_m1_rvalid;
  logic        i_m0_rready, i_m1_rready;
  logic [31:0] o_axi_araddr;
  logic [3:0]  o_axi_arid;
  logic [7:0]  o_axi_arlen;
  logic [2:0]  o_axi_arsize;
  logic [1:0]  o_axi_arburst;
  logic        o_axi_arvalid;
  logic        i_axi_arready;
  logic [31:0] i_axi_rdata;
  logic [1:0]  i_axi_rresp;
  logic [3:0]  i_axi_rid;
  logic        i_axi_rlast;
  logic        i_axi_rvalid;
  logic        o_axi_rready;
  logic [1:0]  o_grant;
  logic        o_busy;

  axi_rd_arbiter dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_m0_araddr(i_m0_araddr), .i_m0_arid(i_m0_arid),
    .i_m0_arlen(i_m0_arlen), .i_m0_arsize(i_m0_arsize),
    .i_m0_arburst(i_m0_arburst), .i_m0_arvalid(i_m0_arvalid),
    .o_m0_arready(o_m0_arready), .o_m0_rdata(o_m0_rdata),
    .o_m0_rresp(o_m0_rresp), .o_m0_rid(o_m0_rid),
    .o_m0_rlast(o_m0_rlast), .o_m0_rvalid(o_m0_rvalid),
    .i_m0_rready(i_m0_rready),
    .i_m1_araddr(i_m1_araddr), .i_m1_arid(i_m1_arid),
    .i_m1_arlen(i_m1_arlen), .i_m1_arsize(i_m1_arsize),
    .i_m1_arburst(i_m1_arburst), .i_m1_arvalid(i_m1_arvalid),
    .o_m1_arready(o_m1_arready), .o_m1_rdata(o_m1_rdata),
    .o_m1_rresp(o_m1_rresp), .o_m1_rid(o_m1_rid),
    .o_m1_rlast(o_m1_rlast), .o_m1_rvalid(o_m1_rvalid),
    .i_m1_rready(i_m1_rready),
    .o_axi_araddr(o_axi_araddr), .o_axi_arid(o_axi_arid),
    .o_axi_arlen(o_axi_arlen), .o_axi_arsize(o_axi_arsize),
    .o_axi_arburst(o_axi_arburst), .o_axi_arvalid(o_axi_arvalid),
    .i_axi_arready(i_axi_arready), .i_axi_rdata(i_axi_rdata),
    .i_axi_rresp(i_axi_rresp), .i_axi_rid(i_axi_rid),
    .i_axi_rlast(i_axi_rlast), .i_axi_rvalid(i_axi_rvalid),
    .o_axi_rready(o_axi_rready),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  always #5 i_clock = ~i_clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic zero_in();
    i_m0_araddr = '0; i_m1_araddr = '0;
    i_m0_arid = 4'd1; i_m1_arid = 4'd2;
    i_m0_arlen = '0; i_m1_arlen = '0;
    i_m0_arsize = 3'd2; i_m1_arsize = 3'd2;
    i_m0_arburst = 2'b01; i_m1_arburst = 2'b01;
    i_m0_arvalid = 1'b0; i_m1_arvalid = 1'b0;
    i_m0_rready = 1'b0; i_m1_rready = 1'b0;
    i_axi_arready = 1'b0; i_axi_rdata = '0;
    i_axi_rresp = '0; i_axi_rid = '0;
    i_axi_rlast = 1'b0; i_axi_rvalid = 1'b0;
  endtask

  task automatic cyc();
    @(posedge i_clock);
    #1;
  endtask

  task automatic rst_pulse();
    zero_in();
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
  endtask

  typedef struct {
    logic m0v; logic [31:0] m0a; logic m1v; logic [31:0] m1a;
    logic arr; logic rv; logic [31:0] rd; logic [1:0] rsp;
    logic rl; logic m0rr; logic m1rr;
    logic [1:0] g; logic busy; logic axv; logic [31:0] axa;
    logic axrr; logic m0ar; logic m1ar; logic m0rv; logic m1rv;
    logic [31:0] m0rd; logic [31:0] m1rd; logic [1:0] m1rsp;
  } vec_t;

  localparam logic I = 1'b1;
  localparam logic O = 1'b0;
  localparam logic [1:0] G0 = 2'b00, G1 = 2'b01, G2 = 2'b10;
  localparam logic [1:0] R0 = 2'b00, RE = 2'b10;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] B0 = 32'h8000_0010, B1 = 32'h8000_1000;
  localparam logic [31:0] C1 = 32'h8000_2000;
  localparam logic [31:0] E0 = 32'h8000_3000, E1 = 32'h8000_4000;
  localparam logic [31:0] D0 = 32'h0000_0413, D1 = 32'h0000_0011;
  localparam logic [31:0] D2 = 32'h0000_0022, D3 = 32'h0000_0033;

  vec_t tbl[17];
  vec_t v;

  // random-phase state
  typedef struct { logic [31:0] d; logic last; } beat_t;
  beat_t       q0[$], q1[$];
  beat_t       bt;
  logic        act[2];
  logic [31:0] ra[2];
  logic [7:0]  rln[2];
  logic        s_busy, s_rv;
  logic [31:0] s_addr;
  logic [7:0]  s_len;
  logic [3:0]  s_id;
  int          s_beat;
  logic        m0hs, m1hs, axhs, m0rh, m1rh, srh;
  logic [31:0] cap_addr;
  logic [7:0]  cap_len;
  logic [3:0]  cap_id;
  int          beat;
  logic        rr_pat[6];

  initial begin
    zero_in();
    tbl[0]  = '{I,A0,O,Z,I,O,Z,R0,O,O,O, G0,O,O,Z,O,O,O,O,O,Z,Z,R0};
    tbl[1]  = '{I,A0,O,Z,I,O,Z,R0,O,O,O, G1,I,I,A0,O,I,O,O,O,Z,Z,R0};
    tbl[2]  = '{O,Z,O,Z,O,I,D0,R0,I,I,O, G1,I,O,Z,I,O,O,I,O,D0,Z,R0};
    tbl[3]  = '{O,Z,O,Z,O,O,Z,R0,O,O,O, G0,O,O,Z,O,O,O,O,O,Z,Z,R0};
    tbl[4]  = '{I,B0,I,B1,O,O,Z,R0,O,O,O, G0,O,O,Z,O,O,O,O,O,Z,Z,R0};
    tbl[5]  = '{I,B0,I,B1,I,O,Z,R0,O,O,O, G2,I,I,B1,O,O,I,O,O,Z,Z,R0};
    tbl[6]  = '{I,B0,O,Z,O,I,D1,R0,I,O,I, G2,I,O,Z,I,O,O,O,I,Z,D1,R0};
    tbl[7]  = '{I,B0,O,Z,O,O,Z,R0,O,O,O, G0,O,O,Z,O,O,O,O,O,Z,Z,R0};
    tbl[8]  = '{I,B0,O,Z,I,O,Z,R0,O,O,O, G1,I,I,B0,O,I,O,O,O,Z,Z,R0};
    tbl[9]  = '{O,Z,O,Z,O,I,D2,R0,I,I,O, G1,I,O,Z,I,O,O,I,O,D2,Z,R0};
    tbl[10] = '{O,Z,O,Z,O,O,Z,R0,O,O,O, G0,O,O,Z,O,O,O,O,O,Z,Z,R0};
    tbl[11] = '{O,Z,I,C1,I,O,Z,R0,O,O,O, G0,O,O,Z,O,O,O,O,O,Z,Z,R0};
    tbl[12] = '{O,Z,I,C1,I,O,Z,R0,O,O,O, G2,I,I,C1,O,O,I,O,O,Z,Z,R0};
    tbl[13] = '{O,Z,O,Z,O,I,D3,RE,I,O,I, G2,I,O,Z,I,O,O,O,I,Z,D3,RE};
    tbl[14] = '{O,Z,O,Z,O,O,Z,R0,O,O,O, G0,O,O,Z,O,O,O,O,O,Z,Z,R0};
    tbl[15] = '{I,E0,I,E1,O,O,Z,R0,O,O,O, G0,O,O,Z,O,O,O,O,O,Z,Z,R0};
`ifdef AXI_RD_ARB_RR_EN
    // last owner was m1 (row 12), so m0 wins the tie
    tbl[16] = '{I,E0,I,E1,O,O,Z,R0,O,O,O, G1,I,I,E0,O,O,O,O,O,Z,Z,R0};
`else
    tbl[16] = '{I,E0,I,E1,O,O,Z,R0,O,O,O, G2,I,I,E1,O,O,O,O,O,Z,Z,R0};
`endif

    repeat (2) @(posedge i_clock);
    #1;
    chk("rst grant", 32'(o_grant), 32'h0);
    chk("rst busy", 32'(o_busy), 32'h0);
    chk("rst arvalid", 32'(o_axi_arvalid), 32'h0);
    i_reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      v = tbl[i];
      i_m0_arvalid = v.m0v; i_m0_araddr = v.m0a;
      i_m1_arvalid = v.m1v; i_m1_araddr = v.m1a;
      i_axi_arready = v.arr; i_axi_rvalid = v.rv;
      i_axi_rdata = v.rd; i_axi_rresp = v.rsp;
      i_axi_rlast = v.rl;
      i_m0_rready = v.m0rr; i_m1_rready = v.m1rr;
      @(negedge i_clock);
      chk($sformatf("r%0d grant", i), 32'(o_grant), 32'(v.g));
      chk($sformatf("r%0d busy", i), 32'(o_busy), 32'(v.busy));
      chk($sformatf("r%0d axv", i), 32'(o_axi_arvalid), 32'(v.axv));
      chk($sformatf("r%0d axa", i), o_axi_araddr, v.axa);
      chk($sformatf("r%0d axrr", i), 32'(o_axi_rready), 32'(v.axrr));
      chk($sformatf("r%0d m0ar", i), 32'(o_m0_arready), 32'(v.m0ar));
      chk($sformatf("r%0d m1ar", i), 32'(o_m1_arready), 32'(v.m1ar));
      chk($sformatf("r%0d m0rv", i), 32'(o_m0_rvalid), 32'(v.m0rv));
      chk($sformatf("r%0d m1rv", i), 32'(o_m1_rvalid), 32'(v.m1rv));
      chk($sformatf("r%0d m0rd", i), o_m0_rdata, v.m0rd);
      chk($sformatf("r%0d m1rd", i), o_m1_rdata, v.m1rd);
      chk($sformatf("r%0d m1rsp", i), 32'(o_m1_rresp), 32'(v.m1rsp));
      @(posedge i_clock);
      #1;
    end

    // burst of 4 on m1 with rready stalls; m0 waits meanwhile
    rst_pulse();
    i_m1_arvalid = 1'b1; i_m1_araddr = 32'h8000_5000;
    i_m1_arlen = 8'd3; i_axi_arready = 1'b1;
    cyc();
    chk("bur grant AR", 32'(o_grant), 32'h2);
    cyc();
    i_m1_arvalid = 1'b0; i_axi_arready = 1'b0;
    i_m0_arvalid = 1'b1; i_m0_araddr = 32'h8000_6000;
    rr_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    beat = 0;
    for (int c = 0; c < 6; c++) begin
      i_m1_rready = rr_pat[c];
      i_axi_rvalid = 1'b1;
      i_axi_rdata = 32'h100 + 32'(beat);
      i_axi_rlast = (beat == 3);
      @(negedge i_clock);
      chk("bur rready", 32'(o_axi_rready), 32'(rr_pat[c]));
      chk("bur grant", 32'(o_grant), 32'h2);
      chk("bur m0 arready", 32'(o_m0_arready), 32'h0);
      chk("bur m1 rvalid", 32'(o_m1_rvalid), 32'h1);
      chk("bur m1 rdata", o_m1_rdata, 32'h100 + 32'(beat));
      if (rr_pat[c]) beat++;
      cyc();
    end
    i_axi_rvalid = 1'b0; i_axi_rlast = 1'b0; i_m1_rready = 1'b0;
    chk("bur idle grant", 32'(o_grant), 32'h0);
    chk("bur idle busy", 32'(o_busy), 32'h0);
    cyc();
    chk("bur m0 grant", 32'(o_grant), 32'h1);
    chk("bur m0 addr", o_axi_araddr, 32'h8000_6000);
    rst_pulse();

    // slave AR back-pressure, plus a dropped arvalid
    i_m0_arvalid = 1'b1; i_m0_araddr = 32'h8000_7000;
    cyc();
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clock);
      chk("bp arvalid", 32'(o_axi_arvalid), 32'h1);
      chk("bp araddr", o_axi_araddr, 32'h8000_7000);
      chk("bp grant", 32'(o_grant), 32'h1);
      chk("bp arready", 32'(o_m0_arready), 32'h0);
      cyc();
    end
    i_m0_arvalid = 1'b0;
    @(negedge i_clock);
    chk("drop arvalid", 32'(o_axi_arvalid), 32'h0);
    chk("drop busy", 32'(o_busy), 32'h1);
    cyc();
    i_m0_arvalid = 1'b1; i_axi_arready = 1'b1;
    @(negedge i_clock);
    chk("bp accept", 32'(o_m0_arready), 32'h1);
    cyc();
    zero_in();
    i_axi_rvalid = 1'b1; i_axi_rlast = 1'b1; i_m0_rready = 1'b1;
    i_axi_rdata = 32'hCAFE_0001;
    @(negedge i_clock);
    chk("bp rdata", o_m0_rdata, 32'hCAFE_0001);
    cyc();
    zero_in();
    chk("bp done", 32'(o_busy), 32'h0);

    // asynchronous reset after beat 2 of 4
    i_m1_arvalid = 1'b1; i_m1_araddr = 32'h8000_8000;
    i_m1_arlen = 8'd3; i_axi_arready = 1'b1;
    cyc();
    cyc();
    i_m1_arvalid = 1'b0; i_axi_arready = 1'b0;
    i_axi_rvalid = 1'b1; i_m1_rready = 1'b1;
    cyc();
    cyc();
    chk("pre-rst rvalid", 32'(o_m1_rvalid), 32'h1);
    #1 i_reset = 1'b1;
    #1;
    chk("arst busy", 32'(o_busy), 32'h0);
    chk("arst grant", 32'(o_grant), 32'h0);
    chk("arst rready", 32'(o_axi_rready), 32'h0);
    chk("arst rvalid", 32'(o_m1_rvalid), 32'h0);
    chk("arst arvalid", 32'(o_axi_arvalid), 32'h0);
    cyc();
    zero_in();
    i_reset = 1'b0;
    i_m0_arvalid = 1'b1; i_m0_araddr = 32'h8000_9000;
    i_axi_arready = 1'b1;
    cyc();
    chk("post-rst grant", 32'(o_grant), 32'h1);
    chk("post-rst addr", o_axi_araddr, 32'h8000_9000);
    rst_pulse();

    // random traffic against a transaction scoreboard
    act = '{1'b0, 1'b0};
    ra = '{32'h0, 32'h0};
    rln = '{8'h0, 8'h0};
    s_busy = 1'b0; s_rv = 1'b0; s_addr = '0; s_len = '0;
    s_id = '0; s_beat = 0;
    for (int c = 0; c < 6000; c++) begin
      if (c >= 3000 && !act[0] && !act[1] && !s_busy) break;
      if (c == 5999) chk("rand drain timeout", 32'h1, 32'h0);
      @(negedge i_clock);
      m0hs = i_m0_arvalid & o_m0_arready;
      m1hs = i_m1_arvalid & o_m1_arready;
      axhs = o_axi_arvalid & i_axi_arready;
      m0rh = o_m0_rvalid & i_m0_rready;
      m1rh = o_m1_rvalid & i_m1_rready;
      srh  = i_axi_rvalid & o_axi_rready;
      chk("rand busy", 32'(o_busy), 32'(|o_grant));
      chk("rand onehot", 32'(o_grant == 2'b11), 32'h0);
      if (m0hs & m1hs) chk("rand dual ar", 32'h1, 32'h0);
      chk("rand ar pair", 32'(axhs), 32'(m0hs | m1hs));
      chk("rand r pair", 32'(srh), 32'(m0rh | m1rh));
      if (axhs) begin
        chk("rand outstanding", 32'(s_busy), 32'h0);
        chk("rand araddr", o_axi_araddr, m1hs ? ra[1] : ra[0]);
        chk("rand arlen", 32'(o_axi_arlen), 32'(m1hs ? rln[1] : rln[0]));
        chk("rand arid", 32'(o_axi_arid), m1hs ? 32'h2 : 32'h1);
        cap_addr = o_axi_araddr;
        cap_len = o_axi_arlen;
        cap_id = o_axi_arid;
      end
      if (m0hs)
        for (int k = 0; k <= int'(rln[0]); k++)
          q0.push_back('{ra[0] + 32'(k) * 4, k == int'(rln[0])});
      if (m1hs)
        for (int k = 0; k <= int'(rln[1]); k++)
          q1.push_back('{ra[1] + 32'(k) * 4, k == int'(rln[1])});
      if (m0rh) begin
        if (q0.size() == 0) chk("rand m0 stray beat", 32'h1, 32'h0);
        else begin
          bt = q0.pop_front();
          chk("rand m0 rdata", o_m0_rdata, bt.d);
          chk("rand m0 rlast", 32'(o_m0_rlast), 32'(bt.last));
        end
      end
      if (m1rh) begin
        if (q1.size() == 0) chk("rand m1 stray beat", 32'h1, 32'h0);
        else begin
          bt = q1.pop_front();
          chk("rand m1 rdata", o_m1_rdata, bt.d);
          chk("rand m1 rlast", 32'(o_m1_rlast), 32'(bt.last));
        end
      end
      cyc();
      if (m0hs) act[0] = 1'b0;
      if (m1hs) act[1] = 1'b0;
      if (axhs) begin
        s_busy = 1'b1; s_rv = 1'b0; s_beat = 0;
        s_addr = cap_addr; s_len = cap_len; s_id = cap_id;
      end
      if (srh) begin
        s_rv = 1'b0;
        if (s_beat == int'(s_len)) s_busy = 1'b0;
        s_beat++;
      end
      for (int m = 0; m < 2; m++)
        if (!act[m] && c < 3000 && ($urandom % 3) == 0) begin
          act[m] = 1'b1;
          ra[m] = $urandom & 32'hFFFF_FFF0;
          rln[m] = 8'($urandom_range(0, 3));
        end
      if (s_busy && !s_rv && ($urandom % 2) == 1) s_rv = 1'b1;
      i_m0_arvalid = act[0]; i_m0_araddr = ra[0]; i_m0_arlen = rln[0];
      i_m1_arvalid = act[1]; i_m1_araddr = ra[1]; i_m1_arlen = rln[1];
      i_axi_arready = 1'($urandom % 2);
      i_axi_rvalid = s_rv;
      i_axi_rdata = s_addr + 32'(s_beat) * 4;
      i_axi_rlast = s_busy && (s_beat == int'(s_len));
      i_axi_rid = s_id;
      i_m0_rready = (($urandom % 4) != 0);
      i_m1_rready = (($urandom % 4) != 0);
    end
    chk("rand m0 leftover", 32'(q0.size()), 32'h0);
    chk("rand m1 leftover", 32'(q1.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
